// File: rtl/recip_pkg.sv
// Shared types for the multi-channel reciprocal engine: divider FSM states and
// a channel-index width helper that stays legal for single-entry ranges.
package recip_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } recip_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/recip_div_core.sv
// Iterative restoring divider computing NUMERATOR / divisor, one quotient bit per
// cycle. No channel knowledge; done_o and the result are presented on the step that finishes.
module recip_div_core
    import recip_pkg::*;
#(
    parameter int          W         = 32,
    parameter logic [63:0] NUMERATOR = 64'd32768
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic         dz_o,
    output logic         done_o,
    output recip_state_e state_o
);

    localparam int            CW       = idx_width(W);
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    recip_state_e  state_q, state_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The partial remainder is below the divisor, so W bits hold it; only the
    // shifted trial value needs the extra bit.
    logic [W:0]    shifted;
    logic          ge;

    always_comb begin
        shifted = {rem_q, quot_q[W-1]};
        ge      = (shifted >= {1'b0, div_q});
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        done_o     = 1'b0;
        dz_o       = 1'b0;
        quotient_o = quot_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    div_d   = divisor_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (div_q == '0) begin
                    quot_d     = '1;
                    quotient_o = '1;
                    dz_o       = 1'b1;
                    done_o     = 1'b1;
                    state_d    = DONE;
                end else begin
                    rem_d   = '0;
                    quot_d  = W'(NUMERATOR);
                    cnt_d   = CNT_INIT;
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d  = ge ? W'(shifted - {1'b0, div_q}) : shifted[W-1:0];
                quot_d = {quot_q[W-2:0], ge};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quotient_o = quot_d;
                    done_o     = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/pipelined_reciprocal_mc.sv
// Multi-channel reciprocal engine: per-channel change detection, round-robin
// arbitration onto one shared divider, and a per-channel result bank.
module pipelined_reciprocal_mc
    import recip_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          W         = 32,
    parameter logic [63:0] NUMERATOR = 64'd32768
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NCH*W-1:0] scan_duration,
    input  logic [NCH-1:0]   force_update,
    output logic [NCH*W-1:0] reciprocal,
    output logic [NCH-1:0]   reciprocal_valid,
    output logic [NCH-1:0]   div_by_zero,
    output logic             busy
);

    localparam int CHW = idx_width(NCH);

    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("pipelined_reciprocal_mc: NCH must be in 1..16");
    end
    if (W < 2) begin : g_bad_w
        $error("pipelined_reciprocal_mc: W must be at least 2");
    end
    if (W < 64 && (NUMERATOR >> W) != 64'd0) begin : g_bad_num
        $error("pipelined_reciprocal_mc: NUMERATOR must be below 2**W");
    end

    logic [NCH*W-1:0] last_q;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   set_vec, gnt_vec;
    logic [CHW-1:0]   rr_q, rr_d;
    logic [CHW-1:0]   chan_q, chan_d;
    logic [CHW-1:0]   gnt_idx;
    logic             gnt;
    logic [W-1:0]     gnt_div;

    logic [NCH*W-1:0] recip_q, recip_d;
    logic [NCH-1:0]   valid_q, valid_d;
    logic [NCH-1:0]   dz_q, dz_d;

    logic [W-1:0]     core_quot;
    logic             core_dz;
    logic             core_done;
    recip_state_e     core_state;

    // Set has priority over the grant clear, so a change on the grant cycle re-queues.
    always_comb begin
        set_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            set_vec[k] = (scan_duration[k*W +: W] != last_q[k*W +: W]) || force_update[k];
        end
        pend_d = (pend_q & ~gnt_vec) | set_vec;
    end

    // Scan from rr_q upward with wrap; the first pending channel wins.
    always_comb begin
        logic [CHW:0]   sum;
        logic [CHW-1:0] cand;
        sum     = '0;
        cand    = '0;
        gnt     = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        gnt_div = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, rr_q} + (CHW+1)'(i);
            if (sum >= (CHW+1)'(NCH)) begin
                sum = sum - (CHW+1)'(NCH);
            end
            cand = sum[CHW-1:0];
            if (!gnt && pend_q[cand] && core_state == IDLE) begin
                gnt           = 1'b1;
                gnt_idx       = cand;
                gnt_vec[cand] = 1'b1;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (gnt && gnt_idx == CHW'(k)) begin
                gnt_div = scan_duration[k*W +: W];
            end
        end
    end

    always_comb begin
        rr_d   = rr_q;
        chan_d = chan_q;
        if (gnt) begin
            chan_d = gnt_idx;
            rr_d   = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        recip_d = recip_q;
        dz_d    = dz_q;
        valid_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (core_done && chan_q == CHW'(k)) begin
                recip_d[k*W +: W] = core_quot;
                dz_d[k]           = core_dz;
                valid_d[k]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            chan_q  <= '0;
            recip_q <= '0;
            valid_q <= '0;
            dz_q    <= '0;
        end else begin
            last_q  <= scan_duration;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            chan_q  <= chan_d;
            recip_q <= recip_d;
            valid_q <= valid_d;
            dz_q    <= dz_d;
        end
    end

    recip_div_core #(
        .W         (W),
        .NUMERATOR (NUMERATOR)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_i    (gnt),
        .divisor_i  (gnt_div),
        .quotient_o (core_quot),
        .dz_o       (core_dz),
        .done_o     (core_done),
        .state_o    (core_state)
    );

    assign reciprocal       = recip_q;
    assign reciprocal_valid = valid_q;
    assign div_by_zero      = dz_q;
    assign busy             = (core_state != IDLE);

endmodule

// File: tb/tb_pipelined_reciprocal_mc.sv
// Bench for pipelined_reciprocal_mc: transaction-level schedule model compared every
// cycle, an in-order result scoreboard, and directed vectors with literal results.
module tb_pipelined_reciprocal_mc;

    localparam int NCH = 4;
    localparam int W   = 32;
    localparam int N   = 32768;
    localparam int LAT_NZ = W + 2;
    localparam int GAP_NZ = W + 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NCH*W-1:0] scan_duration = '0;
    logic [NCH-1:0]   force_update = '0;
    logic [NCH*W-1:0] reciprocal;
    logic [NCH-1:0]   reciprocal_valid;
    logic [NCH-1:0]   div_by_zero;
    logic             busy;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    pipelined_reciprocal_mc #(
        .NCH       (NCH),
        .W         (W),
        .NUMERATOR (64'(N))
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .scan_duration    (scan_duration),
        .force_update     (force_update),
        .reciprocal       (reciprocal),
        .reciprocal_valid (reciprocal_valid),
        .div_by_zero      (div_by_zero),
        .busy             (busy)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [NCH*W-1:0] act,
                         input logic [NCH*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each grant books the shared divider for a fixed number of cycles and
    // schedules one result; edge_cnt counts clock edges since reset release.
    int               edge_cnt = 0;
    int               next_free = 0;
    int               due = 0;
    int               sch_ch = 0;
    logic             sch_on = 1'b0;
    logic [W-1:0]     sch_val = '0;
    logic             sch_dz = 1'b0;
    int               m_rr = 0;
    int               g = 0;
    logic [NCH-1:0]   m_pend = '0;
    logic [NCH-1:0]   gmask = '0;
    logic [W-1:0]     m_last [NCH];
    logic [W-1:0]     e_recip [NCH];
    logic [NCH-1:0]   e_dz = '0;
    logic [NCH-1:0]   e_valid = '0;
    logic [W-1:0]     d = '0;
    logic [W-1:0]     exp_q [$];
    int               exp_ch_q [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt = 0; next_free = 0; sch_on = 1'b0; m_rr = 0;
            m_pend = '0; e_dz = '0; e_valid = '0;
            for (int k = 0; k < NCH; k++) begin
                m_last[k] = '0;
                e_recip[k] = '0;
            end
            exp_q.delete();
            exp_ch_q.delete();
        end else begin
            edge_cnt++;
            e_valid = '0;
            if (sch_on && edge_cnt == due) begin
                e_recip[sch_ch] = sch_val;
                e_dz[sch_ch]    = sch_dz;
                e_valid[sch_ch] = 1'b1;
                sch_on = 1'b0;
            end
            gmask = '0;
            if (edge_cnt >= next_free && m_pend != '0) begin
                for (int i = 0; i < NCH; i++) begin
                    if (gmask == '0 && m_pend[(m_rr + i) % NCH]) begin
                        g = (m_rr + i) % NCH;
                        gmask[g] = 1'b1;
                    end
                end
                d = scan_duration[g*W +: W];
                sch_on = 1'b1;
                sch_ch = g;
                if (d == '0) begin
                    sch_val = '1; sch_dz = 1'b1;
                    due = edge_cnt + 2 - 1;
                    next_free = edge_cnt + 3;
                end else begin
                    sch_val = W'(N / d); sch_dz = 1'b0;
                    due = edge_cnt + LAT_NZ - 1;
                    next_free = edge_cnt + GAP_NZ;
                end
                m_rr = (g + 1) % NCH;
                exp_q.push_back(sch_val);
                exp_ch_q.push_back(g);
            end
            for (int k = 0; k < NCH; k++) begin
                m_pend[k] = (m_pend[k] & ~gmask[k]) |
                            (scan_duration[k*W +: W] != m_last[k]) | force_update[k];
                m_last[k] = scan_duration[k*W +: W];
            end
        end
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    logic [NCH*W-1:0] e_flat;
    logic [NCH-1:0]   ohv;
    logic [W-1:0]     sb_val;
    int               sb_ch;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NCH; k++) e_flat[k*W +: W] = e_recip[k];
            check("cmp_recip", reciprocal, e_flat);
            check("cmp_valid", reciprocal_valid, e_valid);
            check("cmp_dz", div_by_zero, e_dz);
            check("cmp_busy", busy, (edge_cnt < next_free - 1));
            check("valid_onehot0", $onehot0(reciprocal_valid), 1);
            if (reciprocal_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", reciprocal_valid, '0);
                end else begin
                    sb_val = exp_q.pop_front();
                    sb_ch  = exp_ch_q.pop_front();
                    ohv = '0;
                    ohv[sb_ch] = 1'b1;
                    check("sb_channel", reciprocal_valid, ohv);
                    check("sb_value", reciprocal[sb_ch*W +: W], sb_val);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] v);
        scan_duration[ch*W +: W] = v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        scan_duration = '0;
        force_update = '0;
        step(3);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int ch, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (reciprocal_valid[ch]) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL wait_valid ch%0d: no valid within %0d cycles", ch, budget);
        end
    endtask

    // Latency counts cycles from the cycle the stimulus was applied.
    task automatic expect_result(input string tag, input int ch, input int lat_exp,
                                 input logic [W-1:0] val, input logic dz);
        int lat;
        wait_valid(ch, lat_exp + 20, lat);
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_value"}, reciprocal[ch*W +: W], val);
        check({tag, "_dz"}, div_by_zero[ch], dz);
        @(negedge clk);
        check({tag, "_pulse_end"}, reciprocal_valid[ch], 1'b0);
        step(1);
    endtask

    task automatic no_valid(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (reciprocal_valid != '0) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
        step(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        step(3);
        check("rst_recip", reciprocal, '0);
        check("rst_valid", reciprocal_valid, '0);
        check("rst_dz", div_by_zero, '0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        chk_on = 1'b1;
        step(2);

        // 1: single channel, nonzero divisor
        set_ch(0, 32'd256);
        expect_result("t1_ch0_256", 0, 1 + LAT_NZ, 32'd128, 1'b0);

        // 2: zero divisor, then a nonzero one clears dz
        set_ch(2, 32'd0 + 32'd0);
        set_ch(2, 32'd0);
        force_update[2] = 1'b1;
        step(1);
        force_update[2] = 1'b0;
        expect_result("t2_ch2_zero", 2, 2, 32'hFFFF_FFFF, 1'b1);
        set_ch(2, 32'd3);
        expect_result("t2_ch2_3", 2, 1 + LAT_NZ, 32'd10922, 1'b0);

        // 3: all channels at once, served in order 35 cycles apart
        do_reset();
        step(1);
        set_ch(0, 32'd10); set_ch(1, 32'd20); set_ch(2, 32'd40); set_ch(3, 32'd80);
        expect_result("t3_ch0", 0, 1 + LAT_NZ, 32'd3276, 1'b0);
        expect_result("t3_ch1", 1, GAP_NZ - 2, 32'd1638, 1'b0);
        expect_result("t3_ch2", 2, GAP_NZ - 2, 32'd819, 1'b0);
        expect_result("t3_ch3", 3, GAP_NZ - 2, 32'd409, 1'b0);

        // 4: input changes mid-division: stale result, then fresh one
        set_ch(1, 32'd1000);
        step(6);
        set_ch(1, 32'd2000);
        expect_result("t4_stale", 1, 1 + LAT_NZ - 6, 32'd32, 1'b0);
        expect_result("t4_fresh", 1, GAP_NZ - 2, 32'd16, 1'b0);
        set_ch(1, 32'd2000);
        no_valid("t4_same_value_quiet", 60);

        // 5: force_update recompute, and a strobe landing on the grant cycle
        set_ch(3, 32'd7);
        expect_result("t5_ch3_7", 3, 1 + LAT_NZ, 32'd4681, 1'b0);
        force_update[3] = 1'b1;
        step(1);
        force_update[3] = 1'b0;
        expect_result("t5_force", 3, LAT_NZ, 32'd4681, 1'b0);
        force_update[3] = 1'b1;
        step(2);
        force_update[3] = 1'b0;
        expect_result("t5_force_a", 3, LAT_NZ - 1, 32'd4681, 1'b0);
        expect_result("t5_force_b", 3, GAP_NZ - 2, 32'd4681, 1'b0);
        no_valid("t5_no_extra", 60);

        // 6: reset in the middle of an iteration
        set_ch(0, 32'd500);
        step(10);
        reset_n = 1'b0;
        scan_duration = '0;
        force_update = '0;
        #1;
        check("t6_rst_recip", reciprocal, '0);
        check("t6_rst_valid", reciprocal_valid, '0);
        check("t6_rst_dz", div_by_zero, '0);
        check("t6_rst_busy", busy, 1'b0);
        step(2);
        reset_n = 1'b1;
        no_valid("t6_quiet_after_reset", 60);
        set_ch(1, 32'd64);
        expect_result("t6_ch1_64", 1, 1 + LAT_NZ, 32'd512, 1'b0);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
